// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution accumulate/output stage:
// accumulator sizing, lane/kernel slice positions, round+saturate, FSM states.
package cnn_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_ACCUM
    } conv_state_e;

    // Accumulator width: full product plus headroom for the window sample count.
    function automatic int unsigned acc_width(input int unsigned bits, input int unsigned cnt_w);
        return 2 * bits + cnt_w;
    endfunction

    // LSB of lane/kernel slot idx inside a packed map or weight word.
    function automatic int unsigned lane_lsb(input int unsigned idx, input int unsigned bits_shift);
        return idx << bits_shift;
    endfunction

    // LSB of pair (c,l) inside the packed result vector.
    function automatic int unsigned pair_lsb(input int unsigned c, input int unsigned l,
                                             input int unsigned lanes, input int unsigned bits);
        return (c * lanes + l) * bits;
    endfunction

    // Round half-up, drop frac bits, clamp to a signed bw-bit range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int unsigned frac,
                                                     input int unsigned bw);
        logic signed [63:0] v;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        v = acc;
        if (frac != 0)
            v = v + (64'sd1 <<< (frac - 1));
        v  = v >>> frac;
        hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (bw - 1));
        if (v > hi)
            v = hi;
        else if (v < lo)
            v = lo;
        return v;
    endfunction

endpackage

// File: rtl/conv_mac_lane.sv
// One kernel/lane multiply-accumulator with round, saturate and optional
// ReLU (macro CONV_RELU_EN) applied before the result register.
module conv_mac_lane
    import cnn_pkg::*;
#(
    parameter int unsigned bits         = 16,
    parameter int unsigned weight_num_2 = 5,
    parameter int unsigned frac_bits    = 8
) (
    input  logic                   clk_in,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   first,
    input  logic                   last,
    input  logic signed [bits-1:0] map,
    input  logic signed [bits-1:0] weight,
    output logic signed [bits-1:0] result
);

    localparam int unsigned ACC_W = acc_width(bits, weight_num_2);

    logic signed [2*bits-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_sum;
    logic signed [bits-1:0]   w_sat;
    logic signed [bits-1:0]   w_out;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [bits-1:0]   r_result;

    assign w_prod = map * weight;
    // The final sample's product is folded in combinationally so the result
    // registers on the same edge that accepts that sample.
    assign w_sum  = first ? ACC_W'(w_prod) : r_acc + ACC_W'(w_prod);
    assign w_sat  = bits'(round_sat(64'(w_sum), frac_bits, bits));

`ifdef CONV_RELU_EN
    assign w_out = w_sat[bits-1] ? '0 : w_sat;
`else
    assign w_out = w_sat;
`endif

    assign result = r_result;

    // Accumulate on every accepted sample; capture the finished result on the last.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_acc    <= '0;
            r_result <= '0;
        end else if (en) begin
            r_acc <= w_sum;
            if (last)
                r_result <= w_out;
        end
    end

endmodule

// File: rtl/conv_acc_out.sv
// First-layer convolution window consumer: MAC array over conv_num x lanes,
// window/raster counters, output address and frame-done pulse.
// Optional macro CONV_RELU_EN clamps negative results to zero.
module conv_acc_out
    import cnn_pkg::*;
#(
    parameter int unsigned bits         = 16,
    parameter int unsigned bits_shift   = 4,
    parameter int unsigned lanes        = 16,
    parameter int unsigned conv_num     = 4,
    parameter int unsigned weight_num   = 25,
    parameter int unsigned weight_num_2 = 5,
    parameter int unsigned out_length   = 24,
    parameter int unsigned out_height   = 63,
    parameter int unsigned addr_w       = 11,
    parameter int unsigned frac_bits    = 8
) (
    input  logic                              clk_in,
    input  logic                              rst,
    input  logic                              ready,
    input  logic [lanes*bits-1:0]             map,
    input  logic [(conv_num<<bits_shift)-1:0] weight,
    output logic [conv_num*lanes*bits-1:0]    result,
    output logic                              out_valid,
    output logic [addr_w-1:0]                 out_addr,
    output logic                              done
);

    localparam int unsigned COL_W = (out_length > 1) ? $clog2(out_length) : 1;
    localparam int unsigned ROW_W = (out_height > 1) ? $clog2(out_height) : 1;

    conv_state_e             r_state;
    logic [weight_num_2-1:0] r_sample_cnt;
    logic [COL_W-1:0]        r_col;
    logic [ROW_W-1:0]        r_row;
    logic                    r_out_valid;
    logic [addr_w-1:0]       r_out_addr;
    logic                    r_done;

    logic w_first;
    logic w_last;

    assign w_first   = (r_state == ST_IDLE) || (r_sample_cnt == '0);
    assign w_last    = ready && (r_sample_cnt == weight_num_2'(weight_num - 1));
    assign out_valid = r_out_valid;
    assign out_addr  = r_out_addr;
    assign done      = r_done;

    // Window FSM: sample counter, raster position, output strobes and address.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_sample_cnt <= '0;
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_done       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            if (ready) begin
                r_state <= ST_ACCUM;
                if (w_last) begin
                    r_sample_cnt <= '0;
                    r_out_valid  <= 1'b1;
                    r_out_addr   <= addr_w'(r_row * out_length + r_col);
                    if (r_col == COL_W'(out_length - 1)) begin
                        r_col <= '0;
                        if (r_row == ROW_W'(out_height - 1)) begin
                            r_row   <= '0;
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end else begin
                        r_col <= r_col + 1'b1;
                    end
                end else begin
                    r_sample_cnt <= r_sample_cnt + 1'b1;
                end
            end
        end
    end

    for (genvar c = 0; c < conv_num; c++) begin : g_kernel
        for (genvar l = 0; l < lanes; l++) begin : g_lane
            conv_mac_lane #(
                .bits         (bits),
                .weight_num_2 (weight_num_2),
                .frac_bits    (frac_bits)
            ) u_mac (
                .clk_in (clk_in),
                .rst    (rst),
                .en     (ready),
                .first  (w_first),
                .last   (w_last),
                .map    (map[lane_lsb(l, bits_shift) +: bits]),
                .weight (weight[lane_lsb(c, bits_shift) +: bits]),
                .result (result[pair_lsb(c, l, lanes, bits) +: bits])
            );
        end
    end

endmodule

// File: tb/tb_conv_acc_out.sv
// Bench for conv_acc_out: two DUTs (frac 0 and frac 8) on shared stimulus,
// window-level reference model, per-cycle compare, directed literal checks.
module tb_conv_acc_out;

    localparam int BITS  = 16;
    localparam int LANES = 2;
    localparam int CONV  = 2;
    localparam int WN    = 4;
    localparam int OL    = 2;
    localparam int OH    = 2;
    localparam int AW    = 4;
    localparam int RW    = CONV * LANES * BITS;
`ifdef CONV_RELU_EN
    localparam logic [15:0] NEG_EXP = 16'h0000;
`else
    localparam logic [15:0] NEG_EXP = 16'h8000;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    ready = 1'b0;
    logic [LANES*BITS-1:0]   map = '0;
    logic [CONV*BITS-1:0]    weight = '0;
    logic [RW-1:0]           res_a, res_b;
    logic                    ov_a, ov_b, done_a, done_b;
    logic [AW-1:0]           addr_a, addr_b;

    always #5 clk = ~clk;

    conv_acc_out #(
        .bits(16), .bits_shift(4), .lanes(LANES), .conv_num(CONV), .weight_num(WN),
        .weight_num_2(3), .out_length(OL), .out_height(OH), .addr_w(AW), .frac_bits(0)
    ) dut_a (
        .clk_in(clk), .rst(rst), .ready(ready), .map(map), .weight(weight),
        .result(res_a), .out_valid(ov_a), .out_addr(addr_a), .done(done_a)
    );

    conv_acc_out #(
        .bits(16), .bits_shift(4), .lanes(LANES), .conv_num(CONV), .weight_num(WN),
        .weight_num_2(3), .out_length(OL), .out_height(OH), .addr_w(AW), .frac_bits(8)
    ) dut_b (
        .clk_in(clk), .rst(rst), .ready(ready), .map(map), .weight(weight),
        .result(res_b), .out_valid(ov_b), .out_addr(addr_b), .done(done_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    longint          sm[WN][LANES];
    longint          sw[WN][CONV];
    int              n_s  = 0;
    int              widx = 0;
    logic            exp_v = 1'b0;
    logic            exp_d = 1'b0;
    logic [AW-1:0]   exp_addr = '0;
    logic [RW-1:0]   exp_a = '0;
    logic [RW-1:0]   exp_b = '0;

    function automatic logic [15:0] quant(input longint s_in, input int frac);
        longint s;
        s = s_in;
        if (frac > 0)
            s = s + (longint'(1) << (frac - 1));
        s = s >>> frac;
        if (s > 32767)
            s = 32767;
        else if (s < -32768)
            s = -32768;
`ifdef CONV_RELU_EN
        if (s < 0)
            s = 0;
`endif
        return s[15:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                n_s = 0; widx = 0; exp_v = 1'b0; exp_d = 1'b0;
                exp_addr = '0; exp_a = '0; exp_b = '0;
            end else begin
                exp_v = 1'b0;
                exp_d = 1'b0;
                if (ready) begin
                    for (int l = 0; l < LANES; l++)
                        sm[n_s][l] = longint'($signed(map[l*BITS +: BITS]));
                    for (int c = 0; c < CONV; c++)
                        sw[n_s][c] = longint'($signed(weight[c*BITS +: BITS]));
                    n_s++;
                    if (n_s == WN) begin
                        for (int c = 0; c < CONV; c++) begin
                            for (int l = 0; l < LANES; l++) begin
                                longint sum;
                                sum = 0;
                                for (int k = 0; k < WN; k++)
                                    sum += sm[k][l] * sw[k][c];
                                exp_a[(c*LANES+l)*BITS +: BITS] = quant(sum, 0);
                                exp_b[(c*LANES+l)*BITS +: BITS] = quant(sum, 8);
                            end
                        end
                        exp_v    = 1'b1;
                        exp_addr = AW'(widx);
                        exp_d    = (widx == OL*OH - 1);
                        widx     = (widx + 1) % (OL*OH);
                        n_s      = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid_a", 64'(ov_a), 64'(exp_v));
            chk("out_valid_b", 64'(ov_b), 64'(exp_v));
            chk("done_a", 64'(done_a), 64'(exp_d));
            chk("done_b", 64'(done_b), 64'(exp_d));
            chk("out_addr_a", 64'(addr_a), 64'(exp_addr));
            chk("out_addr_b", 64'(addr_b), 64'(exp_addr));
            chk("result_a", 64'(res_a), 64'(exp_a));
            chk("result_b", 64'(res_b), 64'(exp_b));
        end
    end

    // ---------------- directed stimulus ----------------
    // Drives one window (lane0 maps from m0s, kernel0 weight wk0, others random),
    // optionally idling gap_len cycles after sample gap_at; returns the number of
    // cycles from the first drive until out_valid is seen (-1 if never).
    task automatic run_window(input logic [63:0] m0s, input logic [15:0] wk0,
                              input int gap_at, input int gap_len, output int lat);
        int s;
        s   = 0;
        lat = -1;
        for (int cyc = 0; cyc < 30 && lat < 0; cyc++) begin
            if (gap_at >= 0 && cyc > gap_at && cyc <= gap_at + gap_len) begin
                ready = 1'b0;
            end else if (s < WN) begin
                ready              = 1'b1;
                map[15:0]          = m0s[s*16 +: 16];
                map[31:16]         = 16'($urandom);
                weight[15:0]       = wk0;
                weight[31:16]      = 16'($urandom);
                s++;
            end else begin
                ready = 1'b0;
            end
            @(negedge clk);
            if (ov_a)
                lat = cyc + 1;
        end
        ready = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_result_lit", 64'(res_a), 64'd0);
        chk("reset_addr_lit", 64'(addr_a), 64'd0);
        rst = 1'b0;

        run_window({16'd4, 16'd3, 16'd2, 16'd1}, 16'd1, -1, 0, lat);
        chk("lat_gapless", 64'(lat), 64'd4);
        chk("win0_sum_lit", 64'(res_a[15:0]), 64'd10);
        chk("win0_addr_lit", 64'(addr_a), 64'd0);

        run_window({16'd4, 16'd3, 16'd2, 16'd1}, 16'd1, 1, 3, lat);
        chk("lat_gap3", 64'(lat), 64'd7);
        chk("gap_sum_lit", 64'(res_a[15:0]), 64'd10);
        chk("gap_addr_lit", 64'(addr_a), 64'd1);

        run_window({4{16'h7fff}}, 16'h7fff, -1, 0, lat);
        chk("sat_pos_a_lit", 64'(res_a[15:0]), 64'h7fff);
        chk("sat_pos_b_lit", 64'(res_b[15:0]), 64'h7fff);

        run_window({4{16'h8000}}, 16'd1, -1, 0, lat);
        chk("sat_neg_lit", 64'(res_a[15:0]), 64'(NEG_EXP));
        chk("last_addr_lit", 64'(addr_a), 64'd3);
        chk("done_lit", 64'(done_a), 64'd1);

        run_window({4{16'h0180}}, 16'h0100, -1, 0, lat);
        chk("frac8_lit", 64'(res_b[15:0]), 64'h0600);
        chk("frame_wrap_addr_lit", 64'(addr_b), 64'd0);

        // Reset after two samples: partial window must vanish.
        repeat (2) begin
            ready  = 1'b1;
            map    = 32'($urandom);
            weight = 32'($urandom);
            @(negedge clk);
        end
        ready = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        run_window({16'd4, 16'd3, 16'd2, 16'd1}, 16'd1, -1, 0, lat);
        chk("post_rst_lat", 64'(lat), 64'd4);
        chk("post_rst_sum_lit", 64'(res_a[15:0]), 64'd10);
        chk("post_rst_addr_lit", 64'(addr_a), 64'd0);

        // Randomized traffic: an initial gapless burst, then sparse ready and rare resets.
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst   = ($urandom_range(0, 99) == 0);
            ready = (cyc < 40) || ($urandom_range(0, 3) != 0);
            for (int l = 0; l < LANES; l++)
                map[l*BITS +: BITS] = ($urandom_range(0, 3) == 0) ?
                    (($urandom_range(0, 1) == 0) ? 16'h7fff : 16'h8000) : 16'($urandom);
            for (int c = 0; c < CONV; c++)
                weight[c*BITS +: BITS] = ($urandom_range(0, 3) == 0) ?
                    (($urandom_range(0, 1) == 0) ? 16'h7fff : 16'h8000) : 16'($urandom);
            @(negedge clk);
        end
        rst   = 1'b0;
        ready = 1'b0;
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/conv_acc_out.md
# conv_acc_out

Window-stream consumer for the first convolution layer. Accepts the window-ordered pixel stream (parallel lanes of map data plus a matching weight word per cycle) produced by the picture input stage. Multiply-accumulates each `weight_num`-sample window for every lane/kernel pair, then rounds and saturates each result. Writes one result vector per window, with a raster address, toward the feature-map buffer of the next layer.

## Interface
- `bits`, 16, signed fixed-point width of map, weight and result
- `bits_shift`, 4, log2(`bits`); lane slicing uses `<<bits_shift`
- `lanes`, 16, parallel map lanes (`channel_paralell_num`)
- `conv_num`, 4, kernels per weight word
- `weight_num`, 25, samples per window (filter_size²)
- `weight_num_2`, 5, width of sample counter
- `out_length`, 24, windows per output row
- `out_height`, 63, output rows
- `addr_w`, 11, width of `out_addr`
- `frac_bits`, 8, fraction bits of map and weight

Ports:
- `clk_in` in 1, clock
- `rst` in 1, synchronous, active-high
- `ready` in 1, qualifies `map`/`weight` this cycle
- `map` in `lanes*bits`, lane l at `[(l<<bits_shift)+bits-1 : l<<bits_shift]`
- `weight` in `conv_num<<bits_shift`, kernel c at `[(c<<bits_shift)+bits-1 : c<<bits_shift]`
- `result` out `conv_num*lanes*bits`, pair (c,l) at index `c*lanes+l`
- `out_valid` out 1, one-cycle pulse, `result`/`out_addr` valid
- `out_addr` out `addr_w`, `row*out_length+col` of this window
- `done` out 1, one-cycle pulse after last window of the frame

## Operation
- States: IDLE, ACCUM. Reset → IDLE, `sample_cnt`=0, `col`=0, `row`=0.
- IDLE → ACCUM on first `ready`=1; that cycle is sample 0.
- Each cycle with `ready`=1: for all (c,l), `acc[c][l]` is loaded with `map_l*weight_c` when `sample_cnt`=0, else accumulates that product. `sample_cnt` increments.
- `ready`=0: all counters and accumulators hold. There is no timeout.
- Sample `weight_num-1` accepted: `sample_cnt`→0. Results are registered and `out_valid` pulses. `col` increments; at `out_length-1`, `col`→0 and `row` increments.
- Last window (`row`=`out_height-1`, `col`=`out_length-1`): `done` pulses together with that window's `out_valid`. `row`/`col`→0, state→IDLE.
- A new window may start in the cycle right after the last sample of the previous one, so back-to-back windows have no bubble.
- Arithmetic:
  - Product is 2·`bits` signed.
  - Accumulator is 2·`bits`+`weight_num_2` signed and cannot overflow.
  - Result is `acc >>> frac_bits`, rounded half-up by adding `1<<(frac_bits-1)` before the shift (no add when `frac_bits`=0).
  - Result is then saturated to [−2^(bits−1), 2^(bits−1)−1].
- Reset mid-window: the partial window is discarded and no `out_valid` is produced.

## Timing
- Latency: `out_valid` asserts the cycle after the clock edge that accepts the window's last sample.
- `result` and `out_addr` hold their value until the next `out_valid`. `out_valid` and `done` are 0 otherwise.
- Reset values: `result`=0, `out_valid`=0, `out_addr`=0, `done`=0.
- Throughput: one window per `weight_num` accepted cycles.
- No backpressure. The downstream buffer must accept each pulse.

## Configuration
- `CONV_RELU_EN` defined: negative saturated results are replaced by 0 before registering, with no latency change.
- Undefined: signed results pass unchanged.

## Structure
- Shared package `cnn_pkg`:
  - accumulator-width constant function
  - slice-index functions for lane and kernel packing
  - saturation/round function
  - FSM state enum
- Sub-module `conv_mac_lane`: one (c,l) multiply-accumulator with round/saturate. Inputs: `first`, `en`. Output: registered `bits` result.
- The top level owns the FSM, counters and address. It instantiates `conv_num*lanes` copies of `conv_mac_lane`.

## Test plan
- Config `lanes`=1, `conv_num`=1, `weight_num`=4, `frac_bits`=0, 2×2 frame. Map 1,2,3,4 with weight 1 each cycle → `result`=10, `out_addr`=0, `out_valid` one cycle after the 4th sample.
- Same config, four back-to-back windows → `out_addr` 0,1,2,3. `done` pulses with addr 3. FSM returns to IDLE.
- Window with `ready` low for 3 cycles after sample 1 → same sum as the gapless case. `out_valid` is delayed by exactly 3 cycles.
- Map 32767 × weight 32767 for 4 samples → result saturates to 32767. Map −32768 × weight 1 → −32768 without `CONV_RELU_EN`, 0 with it.
- `frac_bits`=8: map 0x0180 (1.5) × weight 0x0100 (1.0), 4 samples → result 0x0600.
- Assert `rst` after sample 2 → no `out_valid`. A following clean window yields the correct sum at `out_addr`=0.
